srf_write_scheduler: RTL and testbench
======================================

// Module: srf_write_scheduler
// PURPOSE
//  Shares the single scalar register file write port among NUM_REQ producers using round-robin arbitration.
//  Each winning write is registered, then driven onto wr_en/wr_dst/wr_data one cycle after it is granted.
//  Also keeps a per-register scoreboard of outstanding writes.
//  Decode checks both read addresses against it and stalls on RAW hazards.
//  Sits between the execute/load producers and the scalar register file.
// PARAMETERS
//  NUM_REQ   3   number of write requesters (2..8)
//  CNT_W     2   width of per-register outstanding-write counter; max count = 2**CNT_W-1
// PORTS
//  clk          in   1            clock; all state updates on posedge
//  rst          in   1            asynchronous, active-high reset
//  req_valid    in   NUM_REQ      requester i has a write pending
//  req_dst      in   4*NUM_REQ    dest reg of requester i, bits [4i+3:4i]
//  req_data     in   16*NUM_REQ   write data of requester i, bits [16i+15:16i]
//  req_gnt      out  NUM_REQ      one-hot, combinational; write i accepted this cycle
//  wr_en        out  1            register file write enable (registered)
//  wr_dst       out  4            register file write address (registered)
//  wr_data      out  16           register file write data (registered)
//  sb_set       in   1            decode issues an instruction that will write sb_set_addr
//  sb_set_addr  in   4            destination being reserved
//  sb_set_ready out  1            combinational; count[sb_set_addr] below max
//  rd_addr_1    in   4            decode source operand 1
//  rd_addr_2    in   4            decode source operand 2
//  rd_busy_1    out  1            combinational; count[rd_addr_1] != 0
//  rd_busy_2    out  1            combinational; count[rd_addr_2] != 0
//  sb_err       out  1            sticky; a commit hit a register whose count was 0
//  idle         out  1            all counts 0 and wr_en low
// BEHAVIOUR
//  Reset (async, rst=1): wr_en=0, wr_dst=0, wr_data=0, rr pointer=0, all 16 counts=0, sb_err=0.
//   Reset mid-operation drops the pending write and every reservation.
//  Handshake: a requester holds valid/dst/data stable until it sees req_gnt[i]=1 in the same cycle.
//   At most one grant per cycle. There is no backpressure from the register file.
//  Arbitration: scan from ptr upward, modulo NUM_REQ; the first valid requester wins.
//   After a grant to k, ptr <= (k+1) mod NUM_REQ. With no grant, ptr holds.
//  Latency: grant in cycle N -> wr_en=1 with that dst/data in cycle N+1.
//   wr_en=0 in any cycle following a cycle with no grant. Back-to-back grants give a write every cycle.
//  Scoreboard: 16 counters of CNT_W bits.
//   inc when sb_set && sb_set_ready.
//   dec on commit, i.e. a cycle with wr_en=1 (uses wr_dst).
//   sb_set with sb_set_ready=0 is ignored; decode must stall.
//   Same cycle inc+dec on the same register: count unchanged.
//   Commit to a register with count 0: count stays 0, sb_err <= 1 (cleared only by rst).
//  Counts saturate at max and never wrap.
//  rd_busy_x reflects counts before this cycle's inc/dec (no forwarding) unless the bypass macro is defined.
// CONFIGURATION
//  SRF_WRITE_BYPASS_EN defined: adds outputs byp_hit_1, byp_hit_2 (1 bit each) and byp_data (16 bits).
//   When wr_en=1, wr_dst==rd_addr_x and count[wr_dst]==1:
//   rd_busy_x=0, byp_hit_x=1, byp_data=wr_data, all in the same cycle.
//   Decode consumes byp_data instead of the register file read.
//  Not defined: those ports are absent; rd_busy_x is purely count!=0. Stall lasts one cycle longer.
// TESTING
//  T1 reset: assert rst mid-burst with counts nonzero.
//   -> outputs zero immediately (async), idle=1 after release, ptr=0.
//  T2 round-robin: req_valid=3'b111 held 6 cycles.
//   -> grants 0,1,2,0,1,2; wr_en each cycle N+1 with matching dst/data.
//  T3 latency: only req1 valid one cycle, dst=5, data=16'hBEEF.
//   -> gnt=3'b010 in cycle N; wr_en=1, wr_dst=5, wr_data=BEEF in N+1 only.
//  T4 scoreboard: sb_set r3 x3, then a 4th set.
//   -> sb_set_ready=0 on the 4th, count stays 3. Three commits to r3 -> rd_busy_1 (rd_addr_1=3) falls after the last.
//  T5 simultaneous: sb_set r7 in the same cycle as a commit to r7 (count=1).
//   -> count stays 1, rd_busy stays 1, sb_err=0.
//  T6 error/bypass: commit to r9 with count 0.
//   -> sb_err=1 sticky. With SRF_WRITE_BYPASS_EN: commit r2 (count=1), rd_addr_2=2.
//   -> rd_busy_2=0, byp_hit_2=1, byp_data=wr_data.

Source files
------------

// File: rtl/srf_write_scheduler_if.sv
// Producer-side write request bus and the registered register-file write port.
interface srf_write_scheduler_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [4*NUM_REQ-1:0]  req_dst;
    logic [16*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_gnt;
    logic                  wr_en;
    logic [3:0]            wr_dst;
    logic [15:0]           wr_data;

    modport master (
        output req_valid, req_dst, req_data,
        input  req_gnt, wr_en, wr_dst, wr_data
    );

    modport slave (
        input  req_valid, req_dst, req_data,
        output req_gnt, wr_en, wr_dst, wr_data
    );
endinterface

// File: rtl/srf_write_scheduler.sv
// Round-robin share of the scalar RF write port (grant comb, write one cycle later, no RF backpressure)
// plus a per-register outstanding-write scoreboard; SRF_WRITE_BYPASS_EN adds commit-cycle forwarding.
module srf_write_scheduler #(
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    srf_write_scheduler_if.slave bus,
    input  logic                 sb_set,
    input  logic [3:0]           sb_set_addr,
    output logic                 sb_set_ready,
    input  logic [3:0]           rd_addr_1,
    input  logic [3:0]           rd_addr_2,
    output logic                 rd_busy_1,
    output logic                 rd_busy_2,
    output logic                 sb_err,
    output logic                 idle
`ifdef SRF_WRITE_BYPASS_EN
    ,
    output logic                 byp_hit_1,
    output logic                 byp_hit_2,
    output logic [15:0]          byp_data
`endif
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [PTR_W-1:0]   sel;
    logic [PTR_W-1:0]   sel_up;
    logic [PTR_W-1:0]   sel_all;
    logic [NUM_REQ-1:0] upper;
    logic [NUM_REQ-1:0] gnt;
    logic               any_gnt;
    logic [3:0]         win_dst;
    logic [15:0]        win_data;
    logic [CNT_W-1:0]   cnt [16];
    logic [15:0]        inc_vec;
    logic [15:0]        dec_vec;

    // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index overall.
    always_comb begin
        upper   = '0;
        sel_up  = '0;
        sel_all = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            upper[i] = bus.req_valid[i] && (PTR_W'(i) >= ptr);
            if (bus.req_valid[i]) sel_all = PTR_W'(i);
            if (upper[i]) sel_up = PTR_W'(i);
        end
        any_gnt  = |bus.req_valid;
        sel      = (|upper) ? sel_up : sel_all;
        ptr_nxt  = (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + PTR_W'(1);
        gnt      = '0;
        win_dst  = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (any_gnt && sel == PTR_W'(i)) begin
                gnt[i]   = 1'b1;
                win_dst  = bus.req_dst[4*i +: 4];
                win_data = bus.req_data[16*i +: 16];
            end
        end
    end

    assign bus.req_gnt  = gnt;
    assign sb_set_ready = (cnt[sb_set_addr] != CNT_MAX);
    assign inc_vec      = (sb_set && sb_set_ready) ? (16'd1 << sb_set_addr) : 16'd0;
    assign dec_vec      = bus.wr_en ? (16'd1 << bus.wr_dst) : 16'd0;

`ifdef SRF_WRITE_BYPASS_EN
    logic commit_last;
    assign commit_last = bus.wr_en && (cnt[bus.wr_dst] == CNT_W'(1));
    assign byp_hit_1   = commit_last && (bus.wr_dst == rd_addr_1);
    assign byp_hit_2   = commit_last && (bus.wr_dst == rd_addr_2);
    assign byp_data    = bus.wr_data;
    assign rd_busy_1   = (cnt[rd_addr_1] != '0) && !byp_hit_1;
    assign rd_busy_2   = (cnt[rd_addr_2] != '0) && !byp_hit_2;
`else
    assign rd_busy_1   = (cnt[rd_addr_1] != '0);
    assign rd_busy_2   = (cnt[rd_addr_2] != '0);
`endif

    always_comb begin
        idle = !bus.wr_en;
        for (int r = 0; r < 16; r++) begin
            if (cnt[r] != '0) idle = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_dst  <= '0;
            bus.wr_data <= '0;
            sb_err      <= 1'b0;
            for (int r = 0; r < 16; r++) cnt[r] <= '0;
        end else begin
            bus.wr_en <= any_gnt;
            if (any_gnt) begin
                ptr         <= ptr_nxt;
                bus.wr_dst  <= win_dst;
                bus.wr_data <= win_data;
            end
            if (bus.wr_en && cnt[bus.wr_dst] == '0) sb_err <= 1'b1;
            // A reservation and a commit to the same register cancel out.
            for (int r = 0; r < 16; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    cnt[r] <= cnt[r] + CNT_W'(1);
                end else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_srf_write_scheduler.sv
// Randomised and directed bench for srf_write_scheduler against a queue-free behavioural model.
module tb_srf_write_scheduler;
    localparam int N   = 3;
    localparam int MAX = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sb_set = 1'b0;
    logic [3:0]  sb_set_addr = '0;
    logic [3:0]  rd_addr_1 = '0;
    logic [3:0]  rd_addr_2 = '0;
    logic        sb_set_ready, rd_busy_1, rd_busy_2, sb_err, idle;
`ifdef SRF_WRITE_BYPASS_EN
    logic        byp_hit_1, byp_hit_2;
    logic [15:0] byp_data;
`endif

    srf_write_scheduler_if #(.NUM_REQ(N)) bus ();

    srf_write_scheduler #(.NUM_REQ(N), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .sb_set(sb_set), .sb_set_addr(sb_set_addr), .sb_set_ready(sb_set_ready),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_busy_1(rd_busy_1), .rd_busy_2(rd_busy_2),
        .sb_err(sb_err), .idle(idle)
`ifdef SRF_WRITE_BYPASS_EN
        , .byp_hit_1(byp_hit_1), .byp_hit_2(byp_hit_2), .byp_data(byp_data)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_ptr;
    bit          m_wr_en;
    logic [3:0]  m_dst;
    logic [15:0] m_data;
    int          m_cnt [16];
    bit          m_err;
    logic [2:0]  e_gnt;
    bit          e_ready, e_busy1, e_busy2, e_idle, e_hit1, e_hit2;

    function automatic int model_winner();
        for (int o = 0; o < N; o++) begin
            int k;
            k = (m_ptr + o) % N;
            if (bus.req_valid[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_wr_en = 0; m_dst = '0; m_data = '0; m_err = 0; e_gnt = '0;
        for (int r = 0; r < 16; r++) m_cnt[r] = 0;
    endtask

    // Effect of one rising edge with the currently applied inputs.
    task automatic model_clock();
        int w, a, d;
        bit inc;
        a   = int'(sb_set_addr);
        d   = int'(m_dst);
        inc = sb_set && (m_cnt[a] < MAX);
        if (m_wr_en && m_cnt[d] == 0) m_err = 1;
        if (!(m_wr_en && inc && a == d)) begin
            if (inc) m_cnt[a] = m_cnt[a] + 1;
            if (m_wr_en && m_cnt[d] > 0) m_cnt[d] = m_cnt[d] - 1;
        end
        w = model_winner();
        if (w >= 0) begin
            m_wr_en = 1;
            m_dst   = bus.req_dst[4*w +: 4];
            m_data  = bus.req_data[16*w +: 16];
            m_ptr   = (w + 1) % N;
        end else begin
            m_wr_en = 0;
        end
    endtask

    task automatic model_comb();
        int w;
        bit last;
        w       = model_winner();
        e_gnt   = (w >= 0) ? 3'(1 << w) : 3'b000;
        e_ready = m_cnt[sb_set_addr] < MAX;
        last    = m_wr_en && m_cnt[m_dst] == 1;
`ifdef SRF_WRITE_BYPASS_EN
        e_hit1  = last && m_dst == rd_addr_1;
        e_hit2  = last && m_dst == rd_addr_2;
`else
        e_hit1  = 0;
        e_hit2  = 0;
        if (last) e_hit1 = 0;
`endif
        e_busy1 = (m_cnt[rd_addr_1] != 0) && !e_hit1;
        e_busy2 = (m_cnt[rd_addr_2] != 0) && !e_hit2;
        e_idle  = !m_wr_en;
        for (int r = 0; r < 16; r++) if (m_cnt[r] != 0) e_idle = 0;
    endtask

    // Inputs are applied on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic [2:0] v, input logic [11:0] d, input logic [47:0] dat,
                         input logic s, input logic [3:0] sa, input logic [3:0] a1, input logic [3:0] a2);
        model_clock();
        @(negedge clk);
        bus.req_valid = v; bus.req_dst = d; bus.req_data = dat;
        sb_set = s; sb_set_addr = sa; rd_addr_1 = a1; rd_addr_2 = a2;
        #1;
        model_comb();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '0; bus.req_dst = '0; bus.req_data = '0;
        sb_set = 0; sb_set_addr = '0; rd_addr_1 = '0; rd_addr_2 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) drive(3'b111, 12'h654, 48'h3333_2222_1111, 1'b1, 4'd3, 4'd3, 4'd0);
        rst = 1'b1;
        #1;
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b want 0", bus.wr_en); end
        checks++; if (bus.wr_dst !== 4'd0) begin errors++; $display("FAIL rst_wr_dst got %h want 0", bus.wr_dst); end
        checks++; if (bus.wr_data !== 16'd0) begin errors++; $display("FAIL rst_wr_data got %h want 0", bus.wr_data); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL rst_sb_err got %b want 0", sb_err); end
        checks++; if (rd_busy_1 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", rd_busy_1); end
        model_reset();
        bus.req_valid = '0; sb_set = 0;
        @(negedge clk);
        rst = 1'b0;
        drive(3'b000, '0, '0, 1'b0, 4'd3, 4'd3, 4'd0);
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %b want 1", idle); end
        drive(3'b111, 12'h321, 48'h0, 1'b0, 4'd3, 4'd3, 4'd0);
        checks++; if (bus.req_gnt !== 3'b001) begin errors++; $display("FAIL rst_ptr got %b want 001", bus.req_gnt); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(3'b111, 12'h321, 48'hC002_C001_C000, 1'b0, 4'd0, 4'd0, 4'd0);
            checks++; if (bus.req_gnt !== 3'(1 << (i % 3))) begin errors++; $display("FAIL rr_gnt cycle %0d got %b want %b", i, bus.req_gnt, 3'(1 << (i % 3))); end
            if (i > 0) begin
                checks++;
                if (bus.wr_en !== 1'b1 || bus.wr_dst !== 4'((i - 1) % 3 + 1) || bus.wr_data !== 16'(16'hC000 + (i - 1) % 3)) begin
                    errors++; $display("FAIL rr_write cycle %0d got en=%b dst=%h data=%h", i, bus.wr_en, bus.wr_dst, bus.wr_data);
                end
            end
        end
        drive(3'b000, '0, '0, 1'b0, 4'd0, 4'd0, 4'd0);
        checks++; if (bus.wr_en !== 1'b1 || bus.wr_dst !== 4'd3 || bus.wr_data !== 16'hC002) begin errors++; $display("FAIL rr_last got en=%b dst=%h data=%h want 1/3/c002", bus.wr_en, bus.wr_dst, bus.wr_data); end
    endtask

    task automatic test_latency();
        apply_reset();
        drive(3'b010, 12'h050, 48'h0000_BEEF_0000, 1'b0, 4'd0, 4'd0, 4'd0);
        checks++; if (bus.req_gnt !== 3'b010 || bus.wr_en !== 1'b0) begin errors++; $display("FAIL lat_grant got gnt=%b en=%b want 010/0", bus.req_gnt, bus.wr_en); end
        drive(3'b000, '0, '0, 1'b0, 4'd0, 4'd0, 4'd0);
        checks++; if (bus.wr_en !== 1'b1 || bus.wr_dst !== 4'd5 || bus.wr_data !== 16'hBEEF) begin errors++; $display("FAIL lat_write got en=%b dst=%h data=%h want 1/5/beef", bus.wr_en, bus.wr_dst, bus.wr_data); end
        drive(3'b000, '0, '0, 1'b0, 4'd0, 4'd0, 4'd0);
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL lat_drop got en=%b want 0", bus.wr_en); end
    endtask

    task automatic test_scoreboard();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            drive(3'b000, '0, '0, 1'b1, 4'd3, 4'd3, 4'd0);
            checks++; if (sb_set_ready !== (k < 3) || rd_busy_1 !== (k > 0)) begin errors++; $display("FAIL sb_set %0d got ready=%b busy=%b", k, sb_set_ready, rd_busy_1); end
        end
        drive(3'b000, '0, '0, 1'b0, 4'd3, 4'd3, 4'd0);
        checks++; if (sb_set_ready !== 1'b0 || rd_busy_1 !== 1'b1) begin errors++; $display("FAIL sb_full got ready=%b busy=%b want 0/1", sb_set_ready, rd_busy_1); end
        for (int k = 0; k < 5; k++) begin
            drive((k < 3) ? 3'b001 : 3'b000, 12'h003, 48'h0000_0000_00AA, 1'b0, 4'd3, 4'd3, 4'd0);
            checks++; if (rd_busy_1 !== (k < 4)) begin errors++; $display("FAIL sb_drain %0d got busy=%b want %b", k, rd_busy_1, (k < 4)); end
        end
        checks++; if (sb_err !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL sb_end got err=%b idle=%b want 0/1", sb_err, idle); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        drive(3'b000, '0, '0, 1'b1, 4'd7, 4'd7, 4'd0);
        drive(3'b100, 12'h700, 48'h1111_0000_0000, 1'b0, 4'd7, 4'd7, 4'd0);
        drive(3'b000, '0, '0, 1'b1, 4'd7, 4'd7, 4'd0);
        checks++; if (bus.wr_en !== 1'b1 || sb_set_ready !== 1'b1) begin errors++; $display("FAIL sim_setup got en=%b ready=%b want 1/1", bus.wr_en, sb_set_ready); end
        drive(3'b000, '0, '0, 1'b0, 4'd7, 4'd7, 4'd0);
        checks++; if (rd_busy_1 !== 1'b1 || sb_err !== 1'b0) begin errors++; $display("FAIL sim_count got busy=%b err=%b want 1/0", rd_busy_1, sb_err); end
        drive(3'b100, 12'h700, 48'h2222_0000_0000, 1'b0, 4'd7, 4'd7, 4'd0);
        drive(3'b000, '0, '0, 1'b0, 4'd7, 4'd7, 4'd0);
        drive(3'b000, '0, '0, 1'b0, 4'd7, 4'd7, 4'd0);
        checks++; if (rd_busy_1 !== 1'b0 || sb_err !== 1'b0) begin errors++; $display("FAIL sim_drain got busy=%b err=%b want 0/0", rd_busy_1, sb_err); end
    endtask

    task automatic test_error_bypass();
        apply_reset();
        drive(3'b001, 12'h009, 48'h0000_0000_0099, 1'b0, 4'd0, 4'd0, 4'd0);
        drive(3'b000, '0, '0, 1'b0, 4'd0, 4'd0, 4'd0);
        drive(3'b000, '0, '0, 1'b0, 4'd0, 4'd0, 4'd0);
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", sb_err); end
        drive(3'b000, '0, '0, 1'b1, 4'd2, 4'd0, 4'd2);
        repeat (2) drive(3'b000, '0, '0, 1'b0, 4'd0, 4'd0, 4'd2);
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", sb_err); end
        drive(3'b001, 12'h002, 48'h0000_0000_1234, 1'b0, 4'd0, 4'd0, 4'd2);
        drive(3'b000, '0, '0, 1'b0, 4'd0, 4'd0, 4'd2);
`ifdef SRF_WRITE_BYPASS_EN
        checks++; if (rd_busy_2 !== 1'b0 || byp_hit_2 !== 1'b1 || byp_data !== 16'h1234 || byp_hit_1 !== 1'b0) begin errors++; $display("FAIL byp_hit got busy=%b hit2=%b hit1=%b data=%h want 0/1/0/1234", rd_busy_2, byp_hit_2, byp_hit_1, byp_data); end
`else
        checks++; if (rd_busy_2 !== 1'b1) begin errors++; $display("FAIL nobyp_busy got %b want 1", rd_busy_2); end
`endif
        drive(3'b000, '0, '0, 1'b0, 4'd0, 4'd0, 4'd2);
        checks++; if (rd_busy_2 !== 1'b0) begin errors++; $display("FAIL byp_after got busy=%b want 0", rd_busy_2); end
    endtask

    task automatic test_random();
        logic [2:0]  rv  = '0;
        logic [11:0] rdv = '0;
        logic [47:0] rdt = '0;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rv[i] && e_gnt[i]) rv[i] = 1'b0;
                if (!rv[i] && $urandom_range(0, 1) == 1) begin
                    rv[i] = 1'b1;
                    rdv[4*i +: 4]   = 4'($urandom_range(0, 3));
                    rdt[16*i +: 16] = 16'($urandom);
                end
            end
            drive(rv, rdv, rdt, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
            checks++; if (bus.req_gnt !== e_gnt) begin errors++; $display("FAIL rnd_gnt cycle %0d got %b want %b", c, bus.req_gnt, e_gnt); end
            checks++; if (bus.wr_en !== m_wr_en || (m_wr_en && (bus.wr_dst !== m_dst || bus.wr_data !== m_data))) begin errors++; $display("FAIL rnd_wr cycle %0d got %b/%h/%h want %b/%h/%h", c, bus.wr_en, bus.wr_dst, bus.wr_data, m_wr_en, m_dst, m_data); end
            checks++; if (sb_set_ready !== e_ready || rd_busy_1 !== e_busy1 || rd_busy_2 !== e_busy2) begin errors++; $display("FAIL rnd_sb cycle %0d got rdy=%b b1=%b b2=%b want %b/%b/%b", c, sb_set_ready, rd_busy_1, rd_busy_2, e_ready, e_busy1, e_busy2); end
            checks++; if (sb_err !== m_err || idle !== e_idle) begin errors++; $display("FAIL rnd_status cycle %0d got err=%b idle=%b want %b/%b", c, sb_err, idle, m_err, e_idle); end
`ifdef SRF_WRITE_BYPASS_EN
            checks++; if (byp_hit_1 !== e_hit1 || byp_hit_2 !== e_hit2) begin errors++; $display("FAIL rnd_byp cycle %0d got %b%b want %b%b", c, byp_hit_1, byp_hit_2, e_hit1, e_hit2); end
`endif
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0; bus.req_dst = '0; bus.req_data = '0;
        model_reset();
        test_reset();
        test_round_robin();
        test_latency();
        test_scoreboard();
        test_simultaneous();
        test_error_bypass();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
